// File: rtl/ctx_pkg.sv
// Shared types and constants for the CTX arbiter.
// Optional grant statistics are enabled with the CTX_ARB_STATS_EN macro.
package ctx_pkg;

   localparam int CTX_DATA_W = 8;
   localparam int CTX_IDX_W  = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2
   } ctx_state_t;

   typedef struct packed {
      logic                 valid;
      logic [CTX_IDX_W-1:0] idx;
   } ctx_tag_t;

endpackage

// File: rtl/ctx_rr_arb.sv
// Round-robin picker: the first requester at or after ptr (wrapping) wins.
module ctx_rr_arb
   import ctx_pkg::*;
#(
   parameter int NREQ = 4
)(
   input  logic [NREQ-1:0]      req,
   input  logic [CTX_IDX_W-1:0] ptr,
   output logic [NREQ-1:0]      grant
);

   int unsigned pos;
   logic        found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      pos   = 0;
      for (int k = 0; k < NREQ; k++) begin
         pos = (32'(ptr) + 32'(k)) % 32'(NREQ);
         for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (pos == 32'(i))) begin
               grant[i] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ctx_arb.sv
// Round-robin arbiter feeding a fixed-latency CTX unit, routing results back by tag.
// Define CTX_ARB_STATS_EN to add per-requester saturating grant counters (grant_cnt).
//
// state  | meaning
// IDLE   | no requests and nothing in flight; also parks here after a flush until flush drops
// ACTIVE | granting and/or results in flight
// DRAIN  | flush seen: no grants, waiting for in-flight tags to retire
module ctx_arb
   import ctx_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int CTX_LAT = 2
)(
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NREQ-1:0]                  req_val,
   input  logic [NREQ-1:0][CTX_DATA_W-1:0]  req_data,
   output logic [NREQ-1:0]                  req_rdy,
   output logic                             ctx_val,
   output logic [CTX_DATA_W-1:0]            ctx_in,
   input  logic [CTX_DATA_W-1:0]            ctx_out,
   output logic [NREQ-1:0]                  rsp_val,
   output logic [CTX_DATA_W-1:0]            rsp_data,
   input  logic                             flush,
   output logic                             flush_done
`ifdef CTX_ARB_STATS_EN
   ,
   output logic [NREQ-1:0][15:0]            grant_cnt
`endif
);

   ctx_state_t            state_q, state_d;
   logic                  flush_hold;
   logic [CTX_IDX_W-1:0]  rr_ptr;
   logic [CTX_IDX_W-1:0]  ctx_idx;
   logic [CTX_IDX_W-1:0]  gnt_idx;
   logic [CTX_DATA_W-1:0] gnt_data;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       rsp_hit;
   logic                  grant_en;
   logic                  any_xfer;
   logic                  tags_busy;
   logic                  pipe_empty;
   ctx_tag_t              tag_q [CTX_LAT];
   ctx_tag_t              tail;

   ctx_rr_arb #(.NREQ(NREQ)) u_rr_arb (
      .req   (req_val),
      .ptr   (rr_ptr),
      .grant (grant)
   );

   // rst_n in the enable keeps req_rdy low while reset is held
   assign grant_en = rst_n && !flush && (state_q != DRAIN);
   assign req_rdy  = grant & {NREQ{grant_en}};
   assign any_xfer = |req_rdy;
   assign tail     = tag_q[CTX_LAT-1];

   always_comb begin
      gnt_idx  = '0;
      gnt_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_rdy[i]) begin
            gnt_idx  = CTX_IDX_W'(i);
            gnt_data = req_data[i];
         end
      end
   end

   always_comb begin
      tags_busy = 1'b0;
      for (int s = 0; s < CTX_LAT; s++) begin
         tags_busy = tags_busy | tag_q[s].valid;
      end
   end

   assign pipe_empty = !tags_busy && !ctx_val;

   always_comb begin
      rsp_hit = '0;
      for (int i = 0; i < NREQ; i++) begin
         rsp_hit[i] = tail.valid && (tail.idx == CTX_IDX_W'(i));
      end
   end

   always_comb begin
      state_d    = state_q;
      flush_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (flush && !flush_hold) begin
               state_d = DRAIN;
            end else if (|req_val && !flush) begin
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            if (flush) begin
               state_d = DRAIN;
            end else if (!(|req_val) && pipe_empty) begin
               state_d = IDLE;
            end
         end
         DRAIN: begin
            if (pipe_empty) begin
               state_d    = IDLE;
               flush_done = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         flush_hold <= 1'b0;
         rr_ptr     <= '0;
         ctx_val    <= 1'b0;
         ctx_idx    <= '0;
         ctx_in     <= '0;
         rsp_val    <= '0;
         rsp_data   <= '0;
         for (int s = 0; s < CTX_LAT; s++) begin
            tag_q[s] <= '0;
         end
      end else begin
         state_q <= state_d;
         // remembers a completed flush so a held flush does not re-enter DRAIN
         if (!flush) begin
            flush_hold <= 1'b0;
         end else if (flush_done) begin
            flush_hold <= 1'b1;
         end
         ctx_val <= any_xfer;
         if (any_xfer) begin
            ctx_in  <= gnt_data;
            ctx_idx <= gnt_idx;
            rr_ptr  <= (gnt_idx == CTX_IDX_W'(NREQ-1)) ? '0 : gnt_idx + CTX_IDX_W'(1);
         end
         tag_q[0] <= '{valid: ctx_val, idx: ctx_idx};
         for (int s = 1; s < CTX_LAT; s++) begin
            tag_q[s] <= tag_q[s-1];
         end
         rsp_val <= rsp_hit;
         if (tail.valid) begin
            rsp_data <= ctx_out;
         end
      end
   end

`ifdef CTX_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_rdy[i] && (grant_cnt[i] != 16'hFFFF)) begin
               grant_cnt[i] <= grant_cnt[i] + 16'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_ctx_arb.sv
// Directed bench for ctx_arb with a CTX model that returns ctx_in+1 after CTX_LAT cycles.
module tb_ctx_arb;

   localparam int NREQ    = 4;
   localparam int CTX_LAT = 2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NREQ-1:0]      req_val;
   logic [NREQ-1:0][7:0] req_data;
   logic [NREQ-1:0]      req_rdy;
   logic                 ctx_val;
   logic [7:0]           ctx_in;
   logic [7:0]           ctx_out;
   logic [NREQ-1:0]      rsp_val;
   logic [7:0]           rsp_data;
   logic                 flush;
   logic                 flush_done;
`ifdef CTX_ARB_STATS_EN
   logic [NREQ-1:0][15:0] grant_cnt;
`endif

   int errs   = 0;
   int checks = 0;

   logic [11:0] exp_q [$];
   logic [11:0] mon_e;
   bit          mon_on = 1'b1;

   logic [7:0]  ctx_pipe [CTX_LAT];

   always #5 clk = ~clk;

   ctx_arb #(.NREQ(NREQ), .CTX_LAT(CTX_LAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_val    (req_val),
      .req_data   (req_data),
      .req_rdy    (req_rdy),
      .ctx_val    (ctx_val),
      .ctx_in     (ctx_in),
      .ctx_out    (ctx_out),
      .rsp_val    (rsp_val),
      .rsp_data   (rsp_data),
      .flush      (flush),
      .flush_done (flush_done)
`ifdef CTX_ARB_STATS_EN
      ,
      .grant_cnt  (grant_cnt)
`endif
   );

   always @(posedge clk) begin
      ctx_pipe[0] <= ctx_in + 8'd1;
      for (int s = 1; s < CTX_LAT; s++) ctx_pipe[s] <= ctx_pipe[s-1];
   end
   assign ctx_out = ctx_pipe[CTX_LAT-1];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // response scoreboard: every rsp_val must match the oldest expected entry
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (mon_on && rst_n && (rsp_val != '0)) begin
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", 32'(rsp_val), 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("rsp_val", 32'(rsp_val), 32'(mon_e[11:8]));
               chk("rsp_data", 32'(rsp_data), 32'(mon_e[7:0]));
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   logic [3:0] cont_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [7:0] cont_rsp [5] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h11};
   int         pulses, done_cyc, last_rsp;
   logic [3:0] rdy_or, rsp_or;

   initial begin
      req_val  = '0;
      req_data = '0;
      flush    = 1'b0;
      rst_n    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      req_val = 4'hF;
      #1;
      chk("rst_rdy", 32'(req_rdy), 32'd0);
      chk("rst_ctx_val", 32'(ctx_val), 32'd0);
      chk("rst_ctx_in", 32'(ctx_in), 32'd0);
      chk("rst_rsp_val", 32'(rsp_val), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_flush_done", 32'(flush_done), 32'd0);
`ifdef CTX_ARB_STATS_EN
      chk("rst_grant_cnt", 32'(|grant_cnt), 32'd0);
`endif
      req_val = '0;
      rst_n   = 1'b1;
      step();

      // sparse: only requester 3, pointer at 0
      req_val     = 4'b1000;
      req_data[3] = 8'h3C;
      #1;
      chk("sparse_gnt", 32'(req_rdy), 32'h8);
      exp_q.push_back({4'b1000, 8'h3D});
      step();

      // contention: pointer wrapped to 0, so grants run 0,1,2,3,0
      req_val  = 4'hF;
      req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("cont_gnt", 32'(req_rdy), 32'(cont_gnt[c]));
         exp_q.push_back({cont_gnt[c], cont_rsp[c]});
         step();
      end
      req_val = '0;
      repeat (8) step();
      chk("cont_drain", 32'(exp_q.size()), 32'd0);

      // single request with exact latency, pointer now 1
      req_val     = 4'b0100;
      req_data[2] = 8'h5A;
      #1;
      chk("single_gnt", 32'(req_rdy), 32'h4);
      exp_q.push_back({4'b0100, 8'h5B});
      step();
      req_val = '0;
      chk("single_ctx_val", 32'(ctx_val), 32'd1);
      chk("single_ctx_in", 32'(ctx_in), 32'h5A);
      step();
      chk("single_ctx_val_off", 32'(ctx_val), 32'd0);
      chk("single_ctx_in_hold", 32'(ctx_in), 32'h5A);
      step();
      chk("single_early", 32'(rsp_val), 32'd0);
      step();
      chk("single_rsp_val", 32'(rsp_val), 32'h4);
      chk("single_rsp_data", 32'(rsp_data), 32'h5B);
      step();

      // flush with two in flight, pointer now 3
      req_val  = 4'b0011;
      req_data = {8'h00, 8'h00, 8'h41, 8'h40};
      #1;
      chk("flush_gnt_a", 32'(req_rdy), 32'h1);
      exp_q.push_back({4'b0001, 8'h41});
      step();
      #1;
      chk("flush_gnt_b", 32'(req_rdy), 32'h2);
      exp_q.push_back({4'b0010, 8'h42});
      step();
      flush = 1'b1;
      #1;
      chk("flush_rdy_now", 32'(req_rdy), 32'd0);
      pulses = 0; done_cyc = -1; last_rsp = -1; rdy_or = '0;
      for (int c = 0; c < 12; c++) begin
         step();
         if (flush_done) begin
            pulses++;
            done_cyc = c;
         end
         if (rsp_val != '0) last_rsp = c;
         rdy_or = rdy_or | req_rdy;
      end
      chk("flush_pulses", 32'(pulses), 32'd1);
      chk("flush_order", 32'((done_cyc >= last_rsp) && (last_rsp >= 0)), 32'd1);
      chk("flush_rdy_held", 32'(rdy_or), 32'd0);
      chk("flush_rsp_all", 32'(exp_q.size()), 32'd0);
      flush   = 1'b0;
      req_val = '0;
      step();
      chk("flush_done_quiet", 32'(flush_done), 32'd0);

      // reset one cycle after a grant to requester 2 (pointer 2)
      req_val     = 4'b0100;
      req_data[2] = 8'h77;
      #1;
      chk("rst_pre_gnt", 32'(req_rdy), 32'h4);
      step();
      req_val = 4'hF;
      rst_n   = 1'b0;
      #1;
      chk("rst_mid_rdy", 32'(req_rdy), 32'd0);
      chk("rst_mid_ctx_val", 32'(ctx_val), 32'd0);
      chk("rst_mid_ctx_in", 32'(ctx_in), 32'd0);
      chk("rst_mid_rsp_val", 32'(rsp_val), 32'd0);
      chk("rst_mid_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_mid_flush_done", 32'(flush_done), 32'd0);
      step();
      req_val = '0;
      rst_n   = 1'b1;
      rsp_or  = '0;
      repeat (6) begin
         step();
         rsp_or = rsp_or | rsp_val;
      end
      chk("rst_no_rsp", 32'(rsp_or), 32'd0);
      req_val  = 4'hF;
      req_data = {8'h53, 8'h52, 8'h51, 8'h50};
      #1;
      chk("rst_next_gnt", 32'(req_rdy), 32'h1);
      exp_q.push_back({4'b0001, 8'h51});
      step();
      req_val = '0;
      repeat (6) step();

`ifdef CTX_ARB_STATS_EN
      mon_on  = 1'b0;
      req_val = 4'b0010;
      repeat (70000) step();
      req_val = '0;
      repeat (6) step();
      mon_on = 1'b1;
      chk("stats_cnt0", 32'(grant_cnt[0]), 32'h0);
      chk("stats_cnt1", 32'(grant_cnt[1]), 32'hFFFF);
      chk("stats_cnt2", 32'(grant_cnt[2]), 32'h0);
      chk("stats_cnt3", 32'(grant_cnt[3]), 32'h0);
`endif

      chk("final_q_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/ctx_arb.md
CTX_ARB -- requirements
Module: ctx_arb

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter: CTX_LAT, default 2, cycles from ctx_val sampled to valid ctx_out (1..8).
REQ-003 Port: clk  input  1  sole clock; all logic on posedge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: req_val  input  NREQ  per-requester request valid.
REQ-006 Port: req_data  input  NREQ x 8  per-requester byte for CTX.
REQ-007 Port: req_rdy  output  NREQ  one-hot grant; transfer when req_val[i] & req_rdy[i].
REQ-008 Port: ctx_val  output  1  drives CTX val.
REQ-009 Port: ctx_in  output  8  drives CTX in.
REQ-010 Port: ctx_out  input  8  CTX result.
REQ-011 Port: rsp_val  output  NREQ  one-hot response strobe to the originating requester.
REQ-012 Port: rsp_data  output  8  registered ctx_out for rsp_val.
REQ-013 Port: flush  input  1  level request to stop granting and drain.
REQ-014 Port: flush_done  output  1  one-cycle pulse when drain completes.

Function
REQ-015 States: IDLE, ACTIVE, DRAIN; one-hot encoding not required.
REQ-016 IDLE -> ACTIVE when any req_val and flush=0; ACTIVE -> IDLE when no req_val and pipeline empty; ACTIVE or IDLE -> DRAIN when flush=1.
REQ-017 DRAIN -> IDLE when tag pipeline empty; flush_done pulses that cycle exactly once, even if flush remains high.
REQ-018 While flush=1 or in DRAIN, req_rdy = 0.
REQ-019 req_rdy combinational from req_val and rr pointer; at most one bit set per cycle.
REQ-020 Round-robin: search starts at rr_ptr; after grant to i, rr_ptr <= (i+1) mod NREQ; no grant leaves rr_ptr unchanged.
REQ-021 On transfer, next cycle ctx_val=1 and ctx_in=req_data[i]; otherwise ctx_val=0, ctx_in holds last value.
REQ-022 Throughput: one grant per cycle, back-to-back allowed.
REQ-023 Tag pipeline depth CTX_LAT carries {valid, requester index} alongside each issued ctx_val.
REQ-024 Tag emerging with valid=1 captures ctx_out; next cycle rsp_val[idx]=1, rsp_data=captured byte.
REQ-025 Total latency: req transfer at cycle T -> rsp_val at cycle T+1+CTX_LAT+1.
REQ-026 Responses return in issue order; no reordering, no loss.
REQ-027 Pipeline empty = no valid tag and ctx_val=0.

Reset
REQ-028 On rst_n low: req_rdy=0 (forced), ctx_val=0, ctx_in=0, rsp_val=0, rsp_data=0, flush_done=0, rr_ptr=0, state IDLE, all tags invalid.
REQ-029 Reset mid-operation discards in-flight tags; no rsp_val for them after release.
REQ-030 Deassertion synchronized in parent; block assumes clean release.

Configuration
REQ-031 Macro CTX_ARB_STATS_EN: when defined, adds output grant_cnt (NREQ x 16), per-requester 16-bit saturating grant counters (hold at 0xFFFF), reset to 0.
REQ-032 Without CTX_ARB_STATS_EN: port and counters absent, all other behaviour identical.

Structure
REQ-033 Package ctx_pkg holds state enum, tag struct {valid, idx}, CTX_DATA_W=8 constant.
REQ-034 Sub-module ctx_rr_arb: NREQ-wide round-robin picker (req vector, pointer in; one-hot grant out).

Verification
REQ-035 Single: req_val[2]=1, data 0x5A, CTX echoes in+1 -> rsp_val[2]=1, rsp_data=0x5B at T+4 (CTX_LAT=2).
REQ-036 Contention: all 4 req_val held -> grants 0,1,2,3,0 on consecutive cycles; responses in same order.
REQ-037 Flush with 2 in flight -> req_rdy=0 immediately; both responses delivered; flush_done single pulse after last.
REQ-038 rst_n low one cycle after grant -> all outputs 0; no rsp_val after release; next grant to requester 0.
REQ-039 CTX_ARB_STATS_EN: 70000 grants to requester 1 -> grant_cnt[1]=0xFFFF, others 0.
REQ-040 Sparse: req_val[3] only, rr_ptr=0 -> grant 3, rr_ptr becomes 0.
